// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - field widths, bit offsets and the packed result layout for top
package top_pkg;

  localparam int W4_W   = 18;
  localparam int W3_W   = 12;
  localparam int W2_W   = 20;
  localparam int W1_W   = 18;
  localparam int W0_W   = 8;
  localparam int CAP_W  = W4_W + W3_W + W2_W + W1_W + W0_W;
  localparam int SUM_W  = 21;
  localparam int PROD_W = 21;
  localparam int XOR_W  = 18;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 32;
  localparam int POP_W  = 7;
  localparam int ABS_W  = 21;
  localparam int Y_W    = 233;

  localparam int CAP_LSB  = 0;
  localparam int CAP_MSB  = 75;
  localparam int SUM_LSB  = 76;
  localparam int SUM_MSB  = 96;
  localparam int PROD_LSB = 97;
  localparam int PROD_MSB = 117;
  localparam int XOR_LSB  = 118;
  localparam int XOR_MSB  = 135;
  localparam int ACC_LSB  = 136;
  localparam int ACC_MSB  = 167;
  localparam int CNT_LSB  = 168;
  localparam int CNT_MSB  = 199;
  localparam int POP_LSB  = 200;
  localparam int POP_MSB  = 206;
  localparam int PAR_BIT  = 207;
  localparam int ABS_LSB  = 208;
  localparam int ABS_MSB  = 228;
  localparam int ZERO_BIT = 229;
  localparam int NEG_BIT  = 230;
  localparam int OVF_BIT  = 231;
  localparam int W0Z_BIT  = 232;

  // Declared MSB first so the struct bit positions match the offsets above.
  typedef struct packed {
    logic              w0_zero;
    logic              ovf;
    logic              neg;
    logic              zero;
    logic [ABS_W-1:0]  absd;
    logic              par;
    logic [POP_W-1:0]  pop;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [XOR_W-1:0]  xr;
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum;
    logic [CAP_W-1:0]  cap;
  } y_t;

  function automatic logic [SUM_W-1:0] sext18_21(input logic [W4_W-1:0] v);
    return {{(SUM_W-W4_W){v[W4_W-1]}}, v};
  endfunction

  function automatic logic [SUM_W-1:0] sext20_21(input logic [W2_W-1:0] v);
    return {{(SUM_W-W2_W){v[W2_W-1]}}, v};
  endfunction

endpackage

// File: rtl/top_stats.sv
// rtl/top_stats.sv - combinational popcount and XOR parity of the 76-bit input capture
module top_stats
  import top_pkg::*;
(
  input  logic [CAP_W-1:0] cap,
  output logic [POP_W-1:0] count,
  output logic             parity
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CAP_W; i++) begin
      count = count + POP_W'(cap[i]);
    end
  end

  assign parity = ^cap;

endmodule

// File: rtl/top.sv
// rtl/top.sv - registered arithmetic/status vector; macro TOP_ACC_EN enables the accumulator and sticky overflow
module top
  import top_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [W4_W-1:0] wire4,
  input  logic        [W3_W-1:0] wire3,
  input  logic signed [W2_W-1:0] wire2,
  input  logic        [W1_W-1:0] wire1,
  input  logic signed [W0_W-1:0] wire0,
  output logic        [Y_W-1:0]  y
);

  y_t y_q;

  logic [CAP_W-1:0]         cap;
  logic [SUM_W-1:0]         sum;
  logic signed [PROD_W-1:0] mul_a;
  logic signed [PROD_W-1:0] mul_b;
  logic signed [PROD_W-1:0] prod;
  logic [SUM_W-1:0]         diff;
  logic [ABS_W-1:0]         absd;
  logic [POP_W-1:0]         pop;
  logic                     par;

  assign cap = {wire4, wire3, wire2, wire1, wire0};
  assign sum = sext18_21(wire4) + sext20_21(wire2);

  // The 21-bit product is exact: |8-bit signed| * 12-bit unsigned stays within 2^20.
  assign mul_a = {{(PROD_W-W0_W){wire0[W0_W-1]}}, wire0};
  assign mul_b = {{(PROD_W-W3_W){1'b0}}, wire3};
  assign prod  = mul_a * mul_b;

  assign diff = sext20_21(wire2) - sext18_21(wire4);
  assign absd = diff[SUM_W-1] ? (~diff + ABS_W'(1)) : diff;

  top_stats u_stats (
    .cap    (cap),
    .count  (pop),
    .parity (par)
  );

`ifdef TOP_ACC_EN
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_step;

  assign addend   = {{(ACC_W-SUM_W){sum[SUM_W-1]}}, sum};
  assign acc_nxt  = y_q.acc + addend;
  // Signed overflow: operands agree in sign but the result does not.
  assign ovf_step = (y_q.acc[ACC_W-1] == addend[ACC_W-1]) &&
                    (acc_nxt[ACC_W-1] != addend[ACC_W-1]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q.cap     <= cap;
      y_q.sum     <= sum;
      y_q.prod    <= prod;
      y_q.xr      <= wire1 ^ wire4;
      y_q.cnt     <= y_q.cnt + CNT_W'(1);
      y_q.pop     <= pop;
      y_q.par     <= par;
      y_q.absd    <= absd;
      y_q.zero    <= (sum == '0);
      y_q.neg     <= sum[SUM_W-1];
      y_q.w0_zero <= (wire0 == '0);
`ifdef TOP_ACC_EN
      y_q.acc     <= acc_nxt;
      y_q.ovf     <= y_q.ovf | ovf_step;
`else
      y_q.acc     <= '0;
      y_q.ovf     <= 1'b0;
`endif
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - self-checking bench for top: per-cycle reference model plus directed literal checks
module tb_top;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [17:0] wire4;
  logic        [11:0] wire3;
  logic signed [19:0] wire2;
  logic        [17:0] wire1;
  logic signed [7:0]  wire0;
  logic       [232:0] y;

  int n_chk  = 0;
  int n_fail = 0;

  top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wire4 (wire4),
    .wire3 (wire3),
    .wire2 (wire2),
    .wire1 (wire1),
    .wire0 (wire0),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [232:0] act, input logic [232:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [17:0] a4, input logic [11:0] a3, input logic [19:0] a2,
                        input logic [17:0] a1, input logic [7:0] a0);
    wire4 = a4; wire3 = a3; wire2 = a2; wire1 = a1; wire0 = a0;
  endtask

  // Reference model: plain integer arithmetic on the captured operands.
  logic [75:0] m_cap;
  int unsigned m_cnt;
  int          m_acc;
  bit          m_ovf;
  bit          m_valid;

  function automatic int sum_of(input logic [75:0] c);
    int a, b;
    a = $signed(c[75:58]);
    b = $signed(c[45:26]);
    return a + b;
  endfunction

  function automatic logic [232:0] model_y(input logic [75:0] c, input int unsigned cnt,
                                           input int acc, input bit ovf);
    logic [232:0] e;
    int a, b, w0, w3, s, p, d;
    a  = $signed(c[75:58]);
    w3 = int'(c[57:46]);
    b  = $signed(c[45:26]);
    w0 = $signed(c[7:0]);
    s  = a + b;
    p  = w0 * w3;
    d  = b - a;
    if (d < 0) d = -d;
    e = '0;
    e[75:0]    = c;
    e[96:76]   = s[20:0];
    e[117:97]  = p[20:0];
    e[135:118] = c[25:8] ^ c[75:58];
`ifdef TOP_ACC_EN
    e[167:136] = acc;
    e[231]     = ovf;
`endif
    e[199:168] = cnt;
    e[206:200] = 7'($countones(c));
    e[207]     = ^c;
    e[228:208] = d[20:0];
    e[229]     = (s == 0);
    e[230]     = (s < 0);
    e[232]     = (w0 == 0);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cap = '0; m_cnt = 0; m_acc = 0; m_ovf = 0; m_valid = 0;
    end else begin
      longint t;
      m_cap   = {wire4, wire3, wire2, wire1, wire0};
      m_cnt   = m_cnt + 1;
      m_valid = 1;
      t = longint'(m_acc) + longint'(sum_of(m_cap));
      if (t > 64'sd2147483647 || t < -64'sd2147483648) m_ovf = 1;
      m_acc = int'(t);
    end
  end

  always @(negedge clk) begin
    if (m_valid) chk("model", y, model_y(m_cap, m_cnt, m_acc, m_ovf));
    else         chk("model_reset", y, '0);
  end

  logic [232:0] e;
  int           n;

  initial begin
    set_in('0, '0, '0, '0, '0);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_in(18'($urandom), 12'($urandom), 20'($urandom), 18'($urandom), 8'($urandom));
      #2 chk("reset_inputs_toggling", y, '0);
    end

    @(negedge clk); #1;
    set_in('0, '0, '0, '0, '0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    e = '0; e[199:168] = 32'd3; e[229] = 1'b1; e[232] = 1'b1;
    chk("zero_inputs_3_edges", y, e);

    #1 rst_n = 1'b0;
    #1 chk("async_reset_midrun", y, '0);
    #1 set_in(18'd1, '0, 20'd2, '0, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("sum_1_plus_2", 233'(y[96:76]), 233'(21'd3));
    chk("absdiff_2_minus_1", 233'(y[228:208]), 233'(21'd1));
    chk("counter_after_reset", 233'(y[199:168]), 233'(32'd2));
`ifdef TOP_ACC_EN
    chk("acc_two_edges", 233'(y[167:136]), 233'(32'd6));
`else
    chk("acc_disabled", 233'(y[167:136]), '0);
`endif

    #1 set_in(18'h0FF00, 12'hFFF, '0, 18'h3C0F0, 8'hFF);
    @(negedge clk);
    chk("prod_neg1_x_4095", 233'(y[117:97]), 233'(21'h1FF001));
    chk("xor_w1_w4", 233'(y[135:118]), 233'(18'h33FF0));

    #1 set_in(18'h20000, '0, 20'h80000, '0, '0);
    @(negedge clk);
    chk("sum_most_negative", 233'(y[96:76]), 233'(21'h160000));
    chk("neg_flag", 233'(y[230]), 233'(1'b1));
    chk("zero_flag_clear", 233'(y[229]), '0);

    #1 set_in('1, '1, '1, '1, '1);
    @(negedge clk);
    chk("popcount_all_ones", 233'(y[206:200]), 233'(7'h4C));
    chk("parity_all_ones", 233'(y[207]), '0);
    chk("absdiff_equal", 233'(y[228:208]), '0);
    chk("w0_zero_clear", 233'(y[232]), '0);

    #1 set_in(18'h1FFFF, 12'h123, 20'h7FFFF, 18'h00001, 8'h80);
    @(negedge clk);
    #1 set_in(18'h3FFFE, 12'h800, 20'h00005, 18'h2AAAA, 8'h7F);
    @(negedge clk);
    #1 set_in(18'h00003, 12'h001, 20'hFFFFD, 18'h15555, 8'h01);
    @(negedge clk);
    chk("sum_cancel_zero", 233'(y[229]), 233'(1'b1));

    #1 rst_n = 1'b0;
    #1 set_in(18'h1FFFF, '0, 20'h7FFFF, '0, '0);
    rst_n = 1'b1;
`ifdef TOP_ACC_EN
    n = 0;
    while (!y[231] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_set", 233'(y[231]), 233'(1'b1));
    chk("ovf_edge_count", 233'(n), 233'(3277));
    #1 set_in('0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", 233'(y[231]), 233'(1'b1));
`else
    repeat (20) @(negedge clk);
    chk("ovf_disabled", 233'(y[231]), '0);
    chk("acc_disabled_max", 233'(y[167:136]), '0);
`endif
    #1 rst_n = 1'b0;
    #1 chk("ovf_cleared_by_reset", 233'(y[231]), '0);
    chk("reset_clears_all", y, '0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
- REQ-001: clk  input  1  rising-edge clock for all state.
- REQ-002: rst_n  input  1  asynchronous, active-low reset.
- REQ-003: wire4  input  18, signed  operand A.
- REQ-004: wire3  input  12, unsigned  multiplier operand.
- REQ-005: wire2  input  20, signed  operand B.
- REQ-006: wire1  input  18, unsigned  mask operand.
- REQ-007: wire0  input  8, signed  multiplicand.
- REQ-008: y  output  233 [232:0]  registered status/result vector.

Function
- REQ-009: y SHALL be driven only from registers; no combinational input-to-output path.
- REQ-010: Latency SHALL be 1 cycle: fields reflect inputs sampled at the latest rising clk edge.
- REQ-011: y[75:0] SHALL hold the input capture {wire4, wire3, wire2, wire1, wire0}.
- REQ-012: y[96:76] SHALL hold sum21 = sext21(wire4) + sext21(wire2), in two's complement, never saturating.
- REQ-013: y[117:97] SHALL hold the 21-bit signed product wire0 * {1'b0, wire3}.
- REQ-014: y[135:118] SHALL hold wire1 ^ wire4 as a bitwise XOR of the raw bits.
- REQ-015: y[167:136] SHALL hold the 32-bit accumulator.
  - Each edge: acc <= acc + sext32(sum21 of current inputs).
  - Wraps modulo 2^32.
- REQ-016: y[199:168] SHALL hold the cycle counter, which increments by 1 every edge after reset release and wraps at 2^32.
- REQ-017: y[206:200] SHALL hold the popcount of the 76-bit input capture (range 0..76).
- REQ-018: y[207] SHALL hold the XOR-parity of the 76-bit input capture.
- REQ-019: y[228:208] SHALL hold |sext21(wire2) - sext21(wire4)| as a 21-bit unsigned value.
- REQ-020: y[229] SHALL be 1 iff sum21 == 0.
- REQ-021: y[230] SHALL be 1 iff sum21 is negative.
- REQ-022: y[231] SHALL be a sticky accumulator signed-overflow flag.
  - Sets when an accumulate step overflows signed 32-bit.
  - Clears only by reset.
- REQ-023: y[232] SHALL be 1 iff wire0 == 0.
- REQ-024: All fields SHALL update on the same edge; an overflow and a wrap occurring on the same cycle are both recorded.

Reset
- REQ-025: rst_n low SHALL immediately clear every register, so y = 0, independent of clk.
- REQ-026: On the first rising edge after rst_n rises, counter SHALL become 1 and the other fields SHALL reflect the inputs at that edge.
- REQ-027: Asserting reset mid-operation SHALL discard the accumulator, counter and sticky flag with no residue.

Configuration
- REQ-028: Macro TOP_ACC_EN SHALL control the accumulator feature.
  - Defined: accumulator (REQ-015) and overflow flag (REQ-022) are present.
  - Undefined: y[167:136] and y[231] are constant 0 and no accumulator logic is synthesized.

Structure
- REQ-029: Package top_pkg SHALL hold all field widths and bit offsets as localparams (input widths, Y_W = 233, every field LSB/MSB).
- REQ-030: Popcount and parity SHALL live in one sub-module, top_stats.
  - Input: 76 bits, combinational.
  - Outputs: 7-bit count, 1-bit parity.

Verification
- REQ-031: rst_n = 0 with random inputs toggling -> y == 0 with no clock edge needed.
- REQ-032: All inputs 0, 3 edges after release -> y[199:168] == 3, y[229] == 1, y[232] == 1, all other bits 0.
- REQ-033: wire4 = 1, wire2 = 2, others 0, 2 edges with TOP_ACC_EN defined:
  - y[96:76] == 3.
  - y[228:208] == 1.
  - y[167:136] == 6.
  - Without the macro, y[167:136] == 0.
- REQ-034: wire0 = 8'hFF, wire3 = 12'hFFF -> y[117:97] == 21'h1FF001 (-4095).
- REQ-035: wire4 = 18'h20000, wire2 = 20'h80000 -> y[96:76] == 21'h160000 and y[230] == 1.
- REQ-036: All input bits 1 -> y[206:200] == 7'h4C and y[207] == 0.
- REQ-037: Accumulator overflow:
  - Preload through repeated max-positive sums until a signed 32-bit overflow occurs -> y[231] == 1.
  - The flag stays 1 after the inputs are zeroed.
  - The flag clears only on rst_n.
